// File: rtl/shift_reg_pkg.sv
// Shared constants and helpers for the universal shift register.
// Mode encoding, sequencer states and mode classification.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHL   = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_ROL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_LOAD  = 3'd5;
  localparam logic [2:0] MODE_ASR   = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Modes that move bits and can therefore be repeated by the sequencer.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    logic res;
    res = 1'b0;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: res = 1'b1;
      default:                                          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the universal shifter, shared by the
// single-step and sequenced paths.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             d_sl,
  input  logic             d_sr,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] reset_val,
  output logic [WIDTH-1:0] q_next,
  output logic             so_next,
  output logic             so_valid
);

  always_comb begin
    q_next   = q;
    so_next  = 1'b0;
    so_valid = 1'b0;
    unique case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL: begin
        q_next   = {q[WIDTH-2:0], d_sl};
        so_next  = q[WIDTH-1];
        so_valid = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {d_sr, q[WIDTH-1:1]};
        so_next  = q[0];
        so_valid = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        so_next  = q[WIDTH-1];
        so_valid = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q[0], q[WIDTH-1:1]};
        so_next  = q[0];
        so_valid = 1'b1;
      end
      MODE_LOAD: q_next = p_in;
      MODE_ASR: begin
        q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
        so_next  = q[0];
        so_valid = 1'b1;
      end
      MODE_CLEAR: q_next = reset_val;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with single-step operation and an
// autonomous multi-step sequencer (START/AMT in, BUSY/DONE out).
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      AW        = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic             D_SL,
  input  logic             D_SR,
  input  logic [WIDTH-1:0] P_IN,
  input  logic             START,
  input  logic [AW-1:0]    AMT,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [AW-1:0] AmtMax = AW'(WIDTH);
  localparam logic [AW-1:0] AmtOne = AW'(1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             done_q, done_d;
  logic [2:0]       mode_q, mode_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [AW-1:0]    amt_sat;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_so;
  logic             step_so_valid;

  // While running, the latched mode drives the datapath and MODE is ignored.
  assign step_mode = (state_q == ST_RUN) ? mode_q : MODE;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q         (q_q),
    .mode      (step_mode),
    .d_sl      (D_SL),
    .d_sr      (D_SR),
    .p_in      (P_IN),
    .reset_val (RESET_VAL),
    .q_next    (step_q),
    .so_next   (step_so),
    .so_valid  (step_so_valid)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    rem_d   = rem_q;
    amt_sat = (AMT > AmtMax) ? AmtMax : AMT;

    if (EN) begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (is_shift_mode(MODE) && (amt_sat != '0)) begin
              // First step happens on the accepting edge.
              q_d    = step_q;
              so_d   = step_so_valid ? step_so : so_q;
              mode_d = MODE;
              if (amt_sat == AmtOne) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_RUN;
                rem_d   = amt_sat - AmtOne;
              end
            end else begin
              if (amt_sat != '0) begin
                q_d = step_q;
              end
              done_d = 1'b1;
            end
          end else begin
            q_d  = step_q;
            so_d = step_so_valid ? step_so : so_q;
          end
        end
        ST_RUN: begin
          q_d   = step_q;
          so_d  = step_so_valid ? step_so : so_q;
          rem_d = rem_q - AmtOne;
          if (rem_q == AmtOne) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      q_q     <= RESET_VAL;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_HOLD;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  assign Q    = q_q;
  assign SO   = so_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=4): stimulus pushes expected
// post-edge outputs, a monitor pops and compares one entry per clock.
module tb_shift_reg_univ;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [2:0] MODE;
  logic       D_SL;
  logic       D_SR;
  logic [3:0] P_IN;
  logic       START;
  logic [2:0] AMT;
  logic [3:0] Q;
  logic       SO;
  logic       BUSY;
  logic       DONE;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  shift_reg_univ #(
    .WIDTH     (4),
    .RESET_VAL (4'b0000)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .MODE  (MODE),
    .D_SL  (D_SL),
    .D_SR  (D_SR),
    .P_IN  (P_IN),
    .START (START),
    .AMT   (AMT),
    .Q     (Q),
    .SO    (SO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and record what must be visible after the edge.
  task automatic cyc(input logic rst_n, input logic en, input logic [2:0] mode,
                     input logic dsl, input logic dsr, input logic [3:0] pin,
                     input logic start, input logic [2:0] amt, input string name,
                     input logic [3:0] eq, input logic eso, input logic ebusy,
                     input logic edone);
    exp_t e;
    RST_N = rst_n;
    EN    = en;
    MODE  = mode;
    D_SL  = dsl;
    D_SR  = dsr;
    P_IN  = pin;
    START = start;
    AMT   = amt;
    e.name = name;
    e.q    = eq;
    e.so   = eso;
    e.busy = ebusy;
    e.done = edone;
    exp_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Q !== e.q || SO !== e.so || BUSY !== e.busy || DONE !== e.done) begin
          n_fail++;
          $display("FAIL %s: got q=%b so=%b busy=%b done=%b, expected q=%b so=%b busy=%b done=%b",
                   e.name, Q, SO, BUSY, DONE, e.q, e.so, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    EN    = 1'b0;
    MODE  = 3'd0;
    D_SL  = 1'b0;
    D_SR  = 1'b0;
    P_IN  = 4'd0;
    START = 1'b0;
    AMT   = 3'd0;
    @(posedge CLK);
    #2;

    // Reset with random inputs, then with EN low.
    cyc(0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
        4'($urandom), 1'($urandom), 3'($urandom), "rst_rand", 4'b0000, 0, 0, 0);
    cyc(0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
        4'($urandom), 1'($urandom), 3'($urandom), "rst_en0", 4'b0000, 0, 0, 0);

    // Single-step SHL fill then SHR drain.
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 0, 3'd0, "shl1", 4'b0001, 0, 0, 0);
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 0, 3'd0, "shl2", 4'b0011, 0, 0, 0);
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 0, 3'd0, "shl3", 4'b0111, 0, 0, 0);
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 0, 3'd0, "shl4", 4'b1111, 0, 0, 0);
    cyc(1, 1, 3'd2, 0, 0, 4'h0, 0, 3'd0, "shr1", 4'b0111, 1, 0, 0);
    cyc(1, 1, 3'd2, 0, 0, 4'h0, 0, 3'd0, "shr2", 4'b0011, 1, 0, 0);
    cyc(1, 1, 3'd2, 0, 0, 4'h0, 0, 3'd0, "shr3", 4'b0001, 1, 0, 0);
    cyc(1, 1, 3'd2, 0, 0, 4'h0, 0, 3'd0, "shr4", 4'b0000, 1, 0, 0);
    cyc(1, 0, 3'd1, 1, 1, 4'h0, 0, 3'd0, "idle_en0", 4'b0000, 1, 0, 0);

    // Sequenced ROL by 3 from 1001.
    cyc(1, 1, 3'd5, 0, 0, 4'b1001, 0, 3'd0, "load1001", 4'b1001, 1, 0, 0);
    cyc(1, 1, 3'd3, 0, 0, 4'h0, 1, 3'd3, "rol_s1", 4'b0011, 1, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "rol_s2", 4'b0110, 0, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "rol_s3", 4'b1100, 0, 0, 1);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "rol_post", 4'b1100, 0, 0, 0);

    // ASR by 4 with stalls and ignored MODE/START changes mid-run.
    cyc(1, 1, 3'd5, 0, 0, 4'b1000, 0, 3'd0, "load1000", 4'b1000, 0, 0, 0);
    cyc(1, 1, 3'd6, 0, 0, 4'h0, 1, 3'd4, "asr_s1", 4'b1100, 0, 1, 0);
    cyc(1, 0, 3'd5, 0, 0, 4'b0101, 1, 3'd1, "asr_stall1", 4'b1100, 0, 1, 0);
    cyc(1, 0, 3'd5, 0, 0, 4'b0101, 0, 3'd1, "asr_stall2", 4'b1100, 0, 1, 0);
    cyc(1, 1, 3'd5, 0, 0, 4'b0101, 1, 3'd1, "asr_s2", 4'b1110, 0, 1, 0);
    cyc(1, 1, 3'd5, 0, 0, 4'b0101, 1, 3'd2, "asr_s3", 4'b1111, 0, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "asr_s4", 4'b1111, 1, 0, 1);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "asr_post", 4'b1111, 1, 0, 0);

    // AMT=0: nothing moves, DONE next cycle.
    cyc(1, 1, 3'd1, 0, 0, 4'h0, 1, 3'd0, "amt0", 4'b1111, 1, 0, 1);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "amt0_post", 4'b1111, 1, 0, 0);

    // AMT=7 saturates to 4 SHR steps with D_SR=0.
    cyc(1, 1, 3'd2, 0, 0, 4'h0, 1, 3'd7, "sat_s1", 4'b0111, 1, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "sat_s2", 4'b0011, 1, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "sat_s3", 4'b0001, 1, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "sat_s4", 4'b0000, 1, 0, 1);

    // Back-to-back START with LOAD while DONE is high.
    cyc(1, 1, 3'd5, 0, 0, 4'b1010, 1, 3'd1, "start_load", 4'b1010, 1, 0, 1);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "load_post", 4'b1010, 1, 0, 0);

    // ROR by 4, aborted by reset with 2 steps remaining.
    cyc(1, 1, 3'd4, 0, 0, 4'h0, 1, 3'd4, "ror_s1", 4'b0101, 0, 1, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "ror_s2", 4'b1010, 1, 1, 0);
    cyc(0, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "abort_rst", 4'b0000, 0, 0, 0);
    cyc(1, 1, 3'd0, 0, 0, 4'h0, 0, 3'd0, "abort_post", 4'b0000, 0, 0, 0);

    // Next START after abort is accepted; D_SL sampled live each step.
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 1, 3'd2, "post_s1", 4'b0001, 0, 1, 0);
    cyc(1, 1, 3'd0, 1, 0, 4'h0, 0, 3'd0, "post_s2", 4'b0011, 0, 0, 1);
    cyc(1, 1, 3'd7, 0, 0, 4'h0, 0, 3'd0, "clear", 4'b0000, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge CLK);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
